// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: opcode encoding, flag bit positions and
// the transaction record held in the output FIFO.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_MUL = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_NOT = 3'b110,
    OP_ILL = 3'b111
  } alu_op_e;

  // Flags are packed as {Z,N,C,V}
  localparam int FLG_V = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;
  localparam int FLG_Z = 3;

  typedef struct packed {
    alu_op_e     opcode;
    logic [15:0] result;
    logic [3:0]  flags;
  } alu_txn_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z/N/C/V derivation for one ALU transaction, plus the
// unsigned-overflow event (arithmetic op with C set).
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [2:0]  opcode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] result,
  output logic [3:0]  flags,
  output logic        ovf_event
);

  logic c;
  logic v;
  logic arith;

  always_comb begin
    c     = 1'b0;
    v     = 1'b0;
    arith = 1'b0;
    case (alu_op_e'(opcode))
      OP_ADD: begin
        arith = 1'b1;
        c     = (17'(a) + 17'(b)) > 17'h0FFFF;
        v     = (a[15] == b[15]) && (result[15] != a[15]);
      end
      OP_SUB: begin
        arith = 1'b1;
        c     = a < b;
        v     = (a[15] != b[15]) && (result[15] != a[15]);
      end
      OP_MUL: begin
        arith = 1'b1;
        c     = (32'(a) * 32'(b)) > 32'h0000FFFF;
        v     = c;
      end
      default: begin
        c = 1'b0;
        v = 1'b0;
      end
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[FLG_Z] = (result == 16'h0000);
    flags[FLG_N] = result[15];
    flags[FLG_C] = c;
    flags[FLG_V] = v;
  end

  assign ovf_event = arith & c;

endmodule

// File: rtl/alu_result_stage.sv
// Captures ALU transactions with derived flags into a small FIFO for writeback,
// and tracks unsigned-overflow events in a sticky bit and saturating counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [15:0]      in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_opcode,
  output logic [15:0]      out_result,
  output logic [3:0]       out_flags,
  output logic             err_illegal,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clear_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  alu_txn_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [3:0] flags;
  logic       ovf_event;
  logic       push;
  logic       enq;
  logic       pop;
  logic       illegal;
  alu_txn_t   head;

  alu_flag_gen u_flag_gen (
    .opcode    (in_opcode),
    .a         (in_a),
    .b         (in_b),
    .result    (in_result),
    .flags     (flags),
    .ovf_event (ovf_event)
  );

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign illegal   = (in_opcode == OP_ILL);
  // Illegal opcodes complete the handshake but never occupy a slot
  assign enq       = push & ~illegal;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= '{opcode: alu_op_e'(in_opcode), result: in_result, flags: flags};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_illegal <= 1'b0;
      ovf_sticky  <= 1'b0;
      ovf_count   <= '0;
    end else begin
      err_illegal <= push & illegal;
      // Clearing wins over a same-cycle event; that event is deliberately lost
      if (clear_ovf) begin
        ovf_sticky <= 1'b0;
        ovf_count  <= '0;
      end else if (push && ovf_event) begin
        ovf_sticky <= 1'b1;
        if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
      end
    end
  end

  assign head       = mem[rd_ptr];
  assign out_opcode = out_valid ? head.opcode : 3'b000;
  assign out_result = out_valid ? head.result : 16'h0000;
  assign out_flags  = out_valid ? head.flags  : 4'b0000;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: a negedge model process tracks FIFO
// contents, flags and overflow bookkeeping from first principles.
module tb_alu_result_stage;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_opcode;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [15:0]      in_result;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_opcode;
  logic [15:0]      out_result;
  logic [3:0]       out_flags;
  logic             err_illegal;
  logic             ovf_sticky;
  logic [CNT_W-1:0] ovf_count;
  logic             clear_ovf;

  alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_result   (in_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .err_illegal (err_illegal),
    .ovf_sticky  (ovf_sticky),
    .ovf_count   (ovf_count),
    .clear_ovf   (clear_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference ALU: what the upstream ALU would drive as in_result
  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      3'd0: return a + b;
      3'd1: return p[15:0];
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  // Flags from integer arithmetic: carry/borrow and signed range overflow
  function automatic logic [3:0] ref_flags(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] r);
    longint ua, ub, sa, sb, t;
    bit z, n, c, v;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    z = (r == 16'h0000);
    n = r[15];
    c = 0; v = 0;
    if (op == 3'd0) begin
      c = (ua + ub) > 65535;
      t = sa + sb;
      v = (t > 32767) || (t < -32768);
    end else if (op == 3'd2) begin
      c = ua < ub;
      t = sa - sb;
      v = (t > 32767) || (t < -32768);
    end else if (op == 3'd1) begin
      c = (ua * ub) > 65535;
      v = c;
    end
    return {z, n, c, v};
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   armed = 0;
  bit   chk_zero = 0;
  bit   exp_err = 0;
  bit   exp_sticky = 0;
  int   exp_cnt = 0;
  int   sz;
  bit   acc;
  logic [3:0] f;

  // Scoreboard: check state produced by edges so far, then model the next edge
  always @(negedge clk) begin
    sz = q.size();
    if (armed) begin
      check("in_ready", 32'(in_ready), 32'(sz < DEPTH));
      check("out_valid", 32'(out_valid), 32'(sz > 0));
      check("err_illegal", 32'(err_illegal), 32'(exp_err));
      check("ovf_sticky", 32'(ovf_sticky), 32'(exp_sticky));
      check("ovf_count", 32'(ovf_count), 32'(exp_cnt));
      if (chk_zero) begin
        check("reset_out_opcode", 32'(out_opcode), 32'd0);
        check("reset_out_result", 32'(out_result), 32'd0);
        check("reset_out_flags", 32'(out_flags), 32'd0);
      end
    end
    if (rst) begin
      q.delete();
      exp_err = 0; exp_sticky = 0; exp_cnt = 0;
      chk_zero = 1;
      armed = 1;
    end else if (armed) begin
      chk_zero = 0;
      acc = in_valid && (sz < DEPTH);
      if (out_valid && out_ready && sz > 0) begin
        e = q.pop_front();
        check("out_opcode", 32'(out_opcode), 32'(e.op));
        check("out_result", 32'(out_result), 32'(e.res));
        check("out_flags", 32'(out_flags), 32'(e.flg));
      end
      exp_err = acc && (in_opcode == 3'b111);
      f = ref_flags(in_opcode, in_a, in_b, in_result);
      if (acc && in_opcode != 3'b111) q.push_back('{op: in_opcode, res: in_result, flg: f});
      if (clear_ovf) begin
        exp_sticky = 0; exp_cnt = 0;
      end else if (acc && in_opcode <= 3'd2 && f[1]) begin
        exp_sticky = 1;
        if (exp_cnt < CNT_MAX) exp_cnt++;
      end
    end
  end

  // Presents one transaction from posedge+1 and holds it until accepted
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_result = alu(op, a, b);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_result = '0;
    out_ready = 1'b1; clear_ovf = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);

    // 1: ADD carry with zero result
    send(3'd0, 16'hFFFF, 16'h0001);
    @(negedge clk);
    check("t1_flags", 32'(out_flags), 32'hA);
    check("t1_count", 32'(ovf_count), 32'd1);
    idle(1);

    // 2: signed overflow only
    send(3'd0, 16'h7FFF, 16'h0001);
    @(negedge clk);
    check("t2_flags", 32'(out_flags), 32'h5);
    check("t2_count", 32'(ovf_count), 32'd1);
    idle(1);

    // 3: MUL overflow, SUB borrow
    send(3'd1, 16'h0100, 16'h0100);
    send(3'd2, 16'h0003, 16'h0005);
    idle(2);
    check("t3_count", 32'(ovf_count), 32'd3);

    // 4: fill while stalled, fifth held until a slot frees
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd3, 16'(i * 16'h1111), 16'hF0F0);
    @(negedge clk);
    check("t4_full", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    fork
      send(3'd4, 16'h1234, 16'h4321);
      begin idle(3); out_ready = 1'b1; end
    join
    idle(6);

    // 5: illegal opcode
    send(3'b111, 16'h5555, 16'hAAAA);
    idle(3);

    // 6: reset mid-stream, then clear_ovf racing a carry
    out_ready = 1'b0;
    send(3'd0, 16'hFFFF, 16'h0002);
    send(3'd5, 16'h00FF, 16'h0F0F);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    out_ready = 1'b1;
    send(3'd0, 16'hFFFF, 16'h0003);
    clear_ovf = 1'b1;
    send(3'd0, 16'hFFFF, 16'h0001);
    clear_ovf = 1'b0;
    @(negedge clk);
    check("t6_clear", 32'(ovf_count), 32'd0);
    idle(1);

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 5; i++) send(3'd1, 16'h0100, 16'h0100);
    idle(2);
    check("sat_count", 32'(ovf_count), 32'(CNT_MAX));

    // Randomized traffic with random backpressure and occasional clears
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clear_ovf = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 4) < 3) begin
        logic [15:0] ra, rb;
        ra = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
        rb = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
        send(3'($urandom_range(0, 7)), ra, rb);
        clear_ovf = 1'b0;
      end else begin
        idle(1);
      end
    end
    out_ready = 1'b1;
    clear_ovf = 1'b0;
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
